// File: rtl/pipelined_addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
// Contents:
//   DEFAULT_WIDTH / DEFAULT_STAGES : default operand width and pipeline depth
//   op_e                           : operation select encoding (add / sub)
//   chunk_width()                  : bits handled by each pipeline stage
//   split_ok()                     : elaboration check that WIDTH splits evenly
//   ovf_flag()                     : signed overflow from the two top carries
package pipelined_addsub_pkg;

  localparam int DEFAULT_WIDTH  = 32'sd64;
  localparam int DEFAULT_STAGES = 32'sd4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Each stage ripples through one equal slice of the operand.
  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // The operand must split into STAGES equal, non-empty chunks.
  function automatic bit split_ok(input int width, input int stages);
    return (stages > 32'sd0) && (width >= stages) && ((width % stages) == 32'sd0);
  endfunction

  // Two's-complement overflow: carry into the MSB differs from carry out of it.
  function automatic logic ovf_flag(input logic carry_msb, input logic carry_out);
    return carry_msb ^ carry_out;
  endfunction

endpackage

// File: rtl/pipelined_addsub_ripple_stage.sv
// Combinational ripple-carry slice used by every pipeline stage.
//
// full_adder   : one-bit full adder cell (a, b, ci -> s, co).
// ripple_stage : CHUNK full adders chained LSB to MSB.
//   a, b   in  CHUNK  operand slices (b already inverted for subtraction)
//   ci     in  1      carry into bit 0
//   s      out CHUNK  slice sum
//   co     out 1      carry out of the slice MSB
//   c_msb  out 1      carry into the slice MSB (needed for signed overflow)

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module ripple_stage
  import pipelined_addsub_pkg::*;
#(
  parameter int CHUNK = chunk_width(DEFAULT_WIDTH, DEFAULT_STAGES)
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  // carry_s[i] is the carry into bit i; carry_s[CHUNK] leaves the slice.
  logic [CHUNK:0] carry_s;

  assign carry_s[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry_s[i]),
      .s  (s[i]),
      .co (carry_s[i+1])
    );
  end

  assign co    = carry_s[CHUNK];
  assign c_msb = carry_s[CHUNK-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor.
//
// The WIDTH-bit operation is split into STAGES chunks of CHUNK bits. The
// operation is first captured in an input register (with b inverted and the
// initial carry fixed up for subtraction), then each stage ripples one chunk
// and registers its carry. Unconsumed operand chunks and already-computed sum
// chunks travel in skew registers so the whole result leaves at once.
// An operation accepted at edge N is presented after edge N+STAGES.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operation offered
//   in_ready   out  1      operation accepted this cycle (= global advance)
//   a, b       in   WIDTH  operands
//   cin        in   1      carry-in (add) / borrow-in (sub)
//   sub        in   1      0: a+b+cin   1: a-b-cin
//   out_valid  out  1      result held on the outputs
//   out_ready  in   1      consumer takes the result
//   sum        out  WIDTH  result modulo 2^WIDTH
//   cout       out  1      carry out of MSB (sub: 1 = no borrow)
//   ovf        out  1      two's-complement overflow
//   zero       out  1      sum == 0
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
    $error("pipelined_addsub: WIDTH must be a positive multiple of STAGES");
  end

  // Global advance: the whole pipeline moves together or not at all, so a
  // stalled result never gets overwritten and bubbles stay where they are.
  logic adv_s;
  op_e  op_s;

  logic             valid0_r;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic             carry0_r;

  logic             out_valid_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             zero_r;

  assign op_s     = op_e'(sub);
  assign adv_s    = out_ready | ~out_valid_r;
  assign in_ready = adv_s;

  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;

  // Operand capture: subtraction becomes a + ~b + ~cin, so only b' and c0 travel on.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid0_r <= 1'b0;
      op_a_r   <= {WIDTH{1'b0}};
      op_b_r   <= {WIDTH{1'b0}};
      carry0_r <= 1'b0;
    end else if (adv_s) begin
      valid0_r <= in_valid;
      op_a_r   <= a;
      op_b_r   <= (op_s == OP_SUB) ? ~b : b;
      carry0_r <= (op_s == OP_SUB) ? ~cin : cin;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // LO: result bits already produced by earlier stages.
    // REM: operand bits not yet consumed (the lowest CHUNK are this stage's).
    localparam int LO  = k * CHUNK;
    localparam int REM = WIDTH - LO;

    logic [REM-1:0]      a_s;
    logic [REM-1:0]      b_s;
    logic                carry_in_s;
    logic                valid_s;
    logic [CHUNK-1:0]    chunk_sum_s;
    logic                chunk_cout_s;
    logic [LO+CHUNK-1:0] sum_s;

    if (k == 0) begin : g_src
      assign a_s        = op_a_r;
      assign b_s        = op_b_r;
      assign carry_in_s = carry0_r;
      assign valid_s    = valid0_r;
      assign sum_s      = chunk_sum_s;
    end else begin : g_src
      logic [REM-1:0] a_r;
      logic [REM-1:0] b_r;
      logic [LO-1:0]  lo_r;
      logic           c_r;
      logic           v_r;

      // Skew registers: shift out the consumed chunk, keep the partial sum, carry the ripple carry.
      always_ff @(posedge clk) begin
        if (rst) begin
          v_r  <= 1'b0;
          c_r  <= 1'b0;
          a_r  <= {REM{1'b0}};
          b_r  <= {REM{1'b0}};
          lo_r <= {LO{1'b0}};
        end else if (adv_s) begin
          v_r  <= g_stage[k-1].valid_s;
          c_r  <= g_stage[k-1].chunk_cout_s;
          a_r  <= g_stage[k-1].a_s[REM+CHUNK-1:CHUNK];
          b_r  <= g_stage[k-1].b_s[REM+CHUNK-1:CHUNK];
          lo_r <= g_stage[k-1].sum_s;
        end
      end

      assign a_s        = a_r;
      assign b_s        = b_r;
      assign carry_in_s = c_r;
      assign valid_s    = v_r;
      assign sum_s      = {chunk_sum_s, lo_r};
    end

    if (k == STAGES - 1) begin : g_tail
      logic cmsb_s;
      logic [WIDTH-1:0] full_sum_s;

      ripple_stage #(.CHUNK(CHUNK)) u_ripple (
        .a     (a_s[CHUNK-1:0]),
        .b     (b_s[CHUNK-1:0]),
        .ci    (carry_in_s),
        .s     (chunk_sum_s),
        .co    (chunk_cout_s),
        .c_msb (cmsb_s)
      );

      assign full_sum_s = sum_s;

      // Result register: flags are derived here from the complete sum and the top carries.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid_r <= 1'b0;
          sum_r       <= {WIDTH{1'b0}};
          cout_r      <= 1'b0;
          ovf_r       <= 1'b0;
          zero_r      <= 1'b0;
        end else if (adv_s) begin
          out_valid_r <= valid_s;
          sum_r       <= full_sum_s;
          cout_r      <= chunk_cout_s;
          ovf_r       <= ovf_flag(cmsb_s, chunk_cout_s);
          zero_r      <= (full_sum_s == {WIDTH{1'b0}});
        end
      end
    end else begin : g_body
      // The carry into a middle chunk's MSB carries no meaning for the result.
      logic cmsb_unused_s;

      ripple_stage #(.CHUNK(CHUNK)) u_ripple (
        .a     (a_s[CHUNK-1:0]),
        .b     (b_s[CHUNK-1:0]),
        .ci    (carry_in_s),
        .s     (chunk_sum_s),
        .co    (chunk_cout_s),
        .c_msb (cmsb_unused_s)
      );
    end
  end

endmodule
